// File: rtl/tbi_err_inject_ctrl.sv
// tbi_err_inject_ctrl: picks the TBI code-groups that get corrupted on the
// TX->RX loopback path. The code-group stream is registered with a fixed
// latency of one cycle. Selected symbols have a latched 10-bit mask XORed onto them.
// Modes: off, single burst, periodic bursts, pseudo-random (LFSR threshold).
// Optional feature macro: TBI_ERR_INJECT_STATS_EN adds err_count_o, which is
// a saturating count of corrupted symbols.
module tbi_err_inject_ctrl #(
  parameter int          g_cnt_width  = 16,
  parameter int          g_prob_width = 10,
  parameter logic [15:0] g_lfsr_seed  = 16'hACE1
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_i,
  input  logic [1:0]              cfg_mode_i,
  input  logic [g_cnt_width-1:0]  cfg_burst_len_i,
  input  logic [g_cnt_width-1:0]  cfg_gap_len_i,
  input  logic [g_prob_width:0]   cfg_prob_i,
  input  logic [9:0]              cfg_mask_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    sym_valid_i,
  input  logic [9:0]              data_i,
  output logic                    valid_o,
  output logic [9:0]              data_o,
  output logic                    corrupt_o,
  output logic                    busy_o,
`ifdef TBI_ERR_INJECT_STATS_EN
  output logic [31:0]             err_count_o,
`endif
  output logic                    done_o
);

  // An all-zero Galois LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] LFSR_INIT = (g_lfsr_seed == 16'h0000) ? 16'h0001 : g_lfsr_seed;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [g_cnt_width-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP, ST_RAND} state_t;

  state_t                  state_q;
  logic [g_cnt_width-1:0]  cnt_q;
  logic [15:0]             lfsr_q;
  logic [15:0]             lfsr_d;
  logic [1:0]              mode_q;
  logic [g_cnt_width-1:0]  burst_len_q;
  logic [g_cnt_width-1:0]  gap_len_q;
  logic [g_prob_width:0]   prob_q;
  logic [9:0]              mask_q;
  logic                    valid_q;
  logic [9:0]              data_q;
  logic                    corrupt_q;
  logic                    done_q;
  logic                    hit;
  logic                    start_acc;

  // A start is taken only from IDLE, only for a non-off mode, and never alongside stop.
  assign start_acc = start_i && !stop_i && (state_q == ST_IDLE) && (cfg_mode_i != 2'd0);

  // One right-shift step of the Galois LFSR.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  // Decide whether the symbol presented this cycle is corrupted.
  // In random mode, the threshold is compared with the LFSR value before it advances.
  always_comb begin
    hit = 1'b0;
    case (state_q)
      ST_BURST: hit = sym_valid_i;
      ST_RAND:  hit = sym_valid_i && ({1'b0, lfsr_q[g_prob_width-1:0]} < prob_q);
      default:  hit = 1'b0;
    endcase
  end

  // Scheduler FSM, config latch, LFSR and the registered datapath outputs.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_INIT;
      mode_q      <= 2'd0;
      burst_len_q <= '0;
      gap_len_q   <= '0;
      prob_q      <= '0;
      mask_q      <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      corrupt_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      valid_q   <= sym_valid_i;
      data_q    <= data_i ^ (hit ? mask_q : 10'h000);
      corrupt_q <= hit;
      done_q    <= 1'b0;

      if ((state_q == ST_RAND) && sym_valid_i)
        lfsr_q <= lfsr_d;

      if (stop_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_acc) begin
              mode_q      <= cfg_mode_i;
              burst_len_q <= cfg_burst_len_i;
              gap_len_q   <= cfg_gap_len_i;
              prob_q      <= cfg_prob_i;
              mask_q      <= cfg_mask_i;
              if (cfg_mode_i == 2'd3) begin
                state_q <= ST_RAND;
              end else if (cfg_burst_len_i != '0) begin
                state_q <= ST_BURST;
                cnt_q   <= cfg_burst_len_i;
              end else if (cfg_mode_i == 2'd1) begin
                // An empty single burst finishes immediately.
                done_q <= 1'b1;
              end
            end
          end
          ST_BURST: begin
            if (sym_valid_i) begin
              if (cnt_q == CNT_ONE) begin
                if (mode_q == 2'd1) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
                end else if (gap_len_q != '0) begin
                  state_q <= ST_GAP;
                  cnt_q   <= gap_len_q;
                end else begin
                  // With a zero gap, the bursts run back to back.
                  cnt_q <= burst_len_q;
                end
              end else begin
                cnt_q <= cnt_q - CNT_ONE;
              end
            end
          end
          ST_GAP: begin
            if (sym_valid_i) begin
              if (cnt_q == CNT_ONE) begin
                state_q <= ST_BURST;
                cnt_q   <= burst_len_q;
              end else begin
                cnt_q <= cnt_q - CNT_ONE;
              end
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

`ifdef TBI_ERR_INJECT_STATS_EN
  logic [31:0] err_count_q;

  // Saturating count of corrupted symbols. The count restarts with each new run.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i || start_acc)
      err_count_q <= '0;
    else if (hit && (err_count_q != 32'hFFFF_FFFF))
      err_count_q <= err_count_q + 32'd1;
  end

  assign err_count_o = err_count_q;
`endif

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign corrupt_o = corrupt_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;

endmodule
